// File: rtl/alu_pkg.sv
// Shared ALU datapath constants: default operand width and carry-lookahead group size.
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_GROUP   = 4;
    localparam int ALU_NGROUPS = ALU_WIDTH / ALU_GROUP;

endpackage : alu_pkg

// File: rtl/cla_group_pg.sv
// Reduces one lookahead group's per-bit propagate/generate terms to group GP/GG.
module cla_group_pg
    import alu_pkg::*;
#(
    parameter int GROUP = ALU_GROUP
) (
    input  logic [GROUP-1:0] p,
    input  logic [GROUP-1:0] g,
    output logic             gp,
    output logic             gg
);

    // NOTE: every output gets a value at the top of the block, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        gp = &p;
        gg = g[0];
        for (int k = 1; k < GROUP; k++) begin
            gg = g[k] | (p[k] & gg);
        end
    end

endmodule : cla_group_pg

// File: rtl/cla_pipe_adder.sv
// Two-stage pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Stage 1 registers per-bit and per-group P/G; stage 2 resolves carries, sum and flags.
module cla_pipe_adder
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int GROUP = ALU_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NGROUPS = WIDTH / GROUP;

    logic               s1_valid;
    logic               s2_valid;
    logic               s2_adv;

    logic [WIDTH-1:0]   bb;
    logic               c0_d;
    logic [WIDTH-1:0]   p_d;
    logic [WIDTH-1:0]   g_d;
    logic [NGROUPS-1:0] gp_d;
    logic [NGROUPS-1:0] gg_d;

    logic [WIDTH-1:0]   s1_p;
    logic [WIDTH-1:0]   s1_g;
    logic [NGROUPS-1:0] s1_gp;
    logic [NGROUPS-1:0] s1_gg;
    logic               s1_c0;

    logic [NGROUPS:0]   gc;
    logic [WIDTH-1:0]   c;
    logic [WIDTH-1:0]   sum_d;

    assign s2_adv    = ~s2_valid | out_ready;
    assign in_ready  = ~s1_valid | s2_adv;
    assign out_valid = s2_valid;

    // Subtraction is a + ~b + 1, so the inversion and forced carry-in happen before P/G.
    assign bb   = sub ? ~b : b;
    assign c0_d = sub | cin;
    assign p_d  = a ^ bb;
    assign g_d  = a & bb;

    for (genvar j = 0; j < NGROUPS; j++) begin : g_grp
        cla_group_pg #(
            .GROUP (GROUP)
        ) u_pg (
            .p  (p_d[j*GROUP +: GROUP]),
            .g  (g_d[j*GROUP +: GROUP]),
            .gp (gp_d[j]),
            .gg (gg_d[j])
        );
    end

    // Group carries come from the lookahead chain; bits inside a group ripple from their group carry.
    always_comb begin
        gc    = '0;
        c     = '0;
        gc[0] = s1_c0;
        for (int j = 0; j < NGROUPS; j++) begin
            gc[j+1] = s1_gg[j] | (s1_gp[j] & gc[j]);
        end
        for (int j = 0; j < NGROUPS; j++) begin
            c[j*GROUP] = gc[j];
            for (int k = 1; k < GROUP; k++) begin
                c[j*GROUP+k] = s1_g[j*GROUP+k-1] | (s1_p[j*GROUP+k-1] & c[j*GROUP+k-1]);
            end
        end
        sum_d = s1_p ^ c;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (s2_adv) begin
                    s2_valid <= s1_valid;
                end
                if (in_ready) begin
                    s1_valid <= in_valid;
                end
            end
            if (s2_adv && s1_valid) begin
                sum      <= sum_d;
                cout     <= gc[NGROUPS];
                overflow <= c[WIDTH-1] ^ gc[NGROUPS];
                zero     <= ~|sum_d;
            end
        end
    end

    // NOTE: stage-1 data regs are deliberately not reset; s1_valid qualifies them, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_p  <= p_d;
            s1_g  <= g_d;
            s1_gp <= gp_d;
            s1_gg <= gg_d;
            s1_c0 <= c0_d;
        end
    end

endmodule : cla_pipe_adder

// File: tb/tb_cla_pipe_adder.sv
// Directed and stall-stream bench for cla_pipe_adder: arithmetic corners, latency,
// back-pressure ordering, flush and asynchronous reset.
module tb_cla_pipe_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        overflow;
    logic        zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cla_pipe_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result {sum, cout, overflow, zero} from plain wide addition.
    function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic mcin, input logic msub);
        logic [31:0] ob;
        logic [32:0] full;
        logic        ovf;
        ob   = msub ? ~mb : mb;
        full = {1'b0, ma} + {1'b0, ob} + {32'd0, (msub ? 1'b1 : mcin)};
        ovf  = (ma[31] == ob[31]) && (full[31] != ma[31]);
        return {full[31:0], full[32], ovf, (full[31:0] == 32'd0)};
    endfunction

    // One beat into an idle pipe: checks acceptance, one-cycle-hidden latency and the result.
    task automatic run_directed(input string tag, input logic [31:0] ta, input logic [31:0] tb_v,
                                input logic tcin, input logic tsub, input logic [31:0] esum,
                                input logic ecout, input logic eovf, input logic ezero);
        a = ta; b = tb_v; cin = tcin; sub = tsub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_sum"},   64'(sum),       64'(esum));
        check({tag, "_cout"},  64'(cout),      64'(ecout));
        check({tag, "_ovf"},   64'(overflow),  64'(eovf));
        check({tag, "_zero"},  64'(zero),      64'(ezero));
    endtask

    // Streams n_beats against a scoreboard; rnd=0 stalls cycles 3-5, rnd=1 stalls at random.
    task automatic stream(input string tag, input int n_beats, input bit rnd);
        logic [34:0] q[$];
        logic [34:0] held;
        logic [34:0] exp;
        logic [31:0] ca, cb;
        logic        ccin, csub;
        bit          have = 1'b0;
        bit          prev_stall = 1'b0;
        bit          in_fire, out_fire;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        int          budget = 4 * n_beats + 40;
        held = '0;
        while (got < n_beats && cyc < budget) begin
            @(posedge clk);
            #1;
            if (sent < n_beats) begin
                if (!have) begin
                    if (rnd) begin
                        ca = $urandom; cb = $urandom;
                        if ($urandom_range(0, 3) == 0) ca = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
                        if ($urandom_range(0, 3) == 0) cb = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0000_0001;
                        ccin = 1'($urandom_range(0, 1));
                        csub = 1'($urandom_range(0, 1));
                    end else begin
                        ca = 32'h1111_1111 * 32'(sent); cb = 32'(sent) + 32'd1;
                        ccin = 1'b1; csub = 1'(sent % 2);
                    end
                    have = 1'b1;
                end
                a = ca; b = cb; cin = ccin; sub = csub; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            if (!rnd && cyc >= 3 && cyc <= 5) check({tag, "_in_ready_full"}, 64'(in_ready), 64'd0);
            if (prev_stall) begin
                check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
                check({tag, "_hold_data"}, 64'({sum, cout, overflow, zero}), 64'(held));
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            if (out_fire) begin
                if (q.size() == 0) begin
                    check({tag, "_out_without_beat"}, 64'(out_valid), 64'd0);
                end else begin
                    exp = q.pop_front();
                    check({tag, "_result"}, 64'({sum, cout, overflow, zero}), 64'(exp));
                end
                got++;
            end
            if (in_fire) begin
                q.push_back(model(ca, cb, ccin, csub));
                sent++;
                have = 1'b0;
            end
            prev_stall = out_valid && !out_ready;
            held = {sum, cout, overflow, zero};
            cyc++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check({tag, "_beats_received"}, 64'(got), 64'(n_beats));
        check({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_cout",      64'(cout),      64'd0);
        check("rst_ovf",       64'(overflow),  64'd0);
        check("rst_zero",      64'(zero),      64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_directed("add_5_3",      32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0);
        run_directed("add_ripple",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_directed("add_cin",      32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_directed("add_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_directed("sub_ovf",      32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        run_directed("sub_borrow",   32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run_directed("sub_equal",    32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        run_directed("sub_cin_ign",  32'h0000_0009, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0005, 1'b1, 1'b0, 1'b0);

        stream("b2b8", 8, 1'b0);
        stream("rand", 10000, 1'b1);

        // Flush with two beats in flight; the concurrent input beat must be dropped too.
        @(posedge clk);
        #1;
        out_ready = 1'b1; a = 32'h0000_0005; b = 32'h0000_0003; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h0000_0010; b = 32'h0000_0020;
        @(posedge clk);
        #1;
        check("fl_pre_valid", 64'(out_valid), 64'd1);
        check("fl_pre_sum",   64'(sum),       64'h8);
        flush = 1'b1; a = 32'h0000_0099; b = 32'h0000_0001; out_ready = 1'b0;
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("fl_out_valid",  64'(out_valid), 64'd0);
        check("fl_in_ready",   64'(in_ready),  64'd1);
        @(posedge clk);
        #1;
        check("fl_drain_valid", 64'(out_valid), 64'd0);
        run_directed("post_flush", 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-operation, asserted away from any clock edge.
        @(posedge clk);
        #1;
        a = 32'h7FFF_FFFF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = 32'h0000_0002; b = 32'h0000_0002;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("ar_pre_valid", 64'(out_valid), 64'd1);
        check("ar_pre_sum",   64'(sum),       64'h8000_0000);
        #1;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(out_valid), 64'd0);
        check("ar_sum",       64'(sum),       64'd0);
        check("ar_ovf",       64'(overflow),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ar_after_valid", 64'(out_valid), 64'd0);
        run_directed("post_reset", 32'h0000_0010, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_000F, 1'b1, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cla_pipe_adder
